// File: rtl/ps_cu_dispatch_pkg.sv
// Shared definitions for the compute-unit dispatch block: instruction field
// layout, unit select codes, flag bit positions and the decoded bundles.
package cu_pkg;
  localparam int AW = 4;

  localparam int CLS_LSB = 29, RN_LSB = 25, RX_LSB = 21, RY_LSB = 17;
  localparam int ALU_LOG = 16, ALU_HC_LSB = 14, ALU_SC_LSB = 11, ALU_SAT = 10;
  localparam int MUL_OTREG = 16, MUL_DT_LSB = 12, MUL_CLS_LSB = 10, MUL_SC_LSB = 8;
  localparam int SHF_CLS_LSB = 15;

  // one-hot unit select as seen on the crossbar write enable {mul,shf,alu}
  localparam logic [2:0] CU_ALU = 3'b001, CU_SHF = 3'b010, CU_MUL = 3'b100;

  localparam int AZ = 0, AN = 1, AC = 2, AV = 3, MV = 4, MN = 5, SV = 6, SZ = 7;
  localparam int STKY_AV = 0, STKY_MV = 1, STKY_SV = 2;

  typedef enum logic [2:0] {
    CLS_NOP = 3'b000, CLS_ALU = 3'b001, CLS_MUL = 3'b010, CLS_SHF = 3'b011,
    CLS_BUSWR = 3'b100, CLS_CLRF = 3'b101, CLS_ILL6 = 3'b110, CLS_ILL7 = 3'b111
  } cls_e;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;

  typedef struct packed {
    logic          alu_en, alu_log, alu_sat;
    logic [1:0]    alu_hc;
    logic [2:0]    alu_sc;
    logic          mul_en, mul_otreg;
    logic [3:0]    mul_dtsts;
    logic [1:0]    mul_cls, mul_sc;
    logic          shf_en;
    logic [1:0]    shf_cls;
    logic [AW-1:0] raddx, raddy;
  } issue_t;

  typedef struct packed {
    logic [2:0]    unit;
    logic [2:0]    cu_en;
    logic          bc_en;
    logic [AW-1:0] rn;
    logic          reads_rf;
    logic          clr;
    logic          illegal;
  } dec_t;
endpackage

// File: rtl/ps_cu_dispatch_if.sv
// Fetch handshake, ps_* control outputs and unit flag inputs of the dispatch block.
interface ps_cu_if #(parameter int ADDRESS_WIDTH = 4, parameter int SIGNAL_WIDTH = 3);
  logic                     instr_valid;
  logic [31:0]              instr;
  logic                     instr_ready;
  logic                     ps_alu_en, ps_alu_log, ps_alu_sat;
  logic [1:0]               ps_alu_hc;
  logic [2:0]               ps_alu_sc;
  logic                     ps_mul_en, ps_mul_otreg;
  logic [3:0]               ps_mul_dtsts;
  logic [1:0]               ps_mul_cls, ps_mul_sc;
  logic                     ps_shf_en;
  logic [1:0]               ps_shf_cls;
  logic [ADDRESS_WIDTH-1:0] ps_xb_raddx, ps_xb_raddy, ps_xb_wadd;
  logic [SIGNAL_WIDTH-1:0]  ps_xb_w_cuEn;
  logic                     ps_xb_w_bcEn;
  logic                     alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av;
  logic                     mul_ps_mv, mul_ps_mn, shf_ps_sv, shf_ps_sz;
  logic [7:0]               astat;
  logic [2:0]               stky;
  logic                     illegal_op;

  modport master (
    input  instr_valid, instr,
    input  alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, mul_ps_mv, mul_ps_mn, shf_ps_sv, shf_ps_sz,
    output instr_ready,
    output ps_alu_en, ps_alu_log, ps_alu_sat, ps_alu_hc, ps_alu_sc,
    output ps_mul_en, ps_mul_otreg, ps_mul_dtsts, ps_mul_cls, ps_mul_sc,
    output ps_shf_en, ps_shf_cls,
    output ps_xb_raddx, ps_xb_raddy, ps_xb_wadd, ps_xb_w_cuEn, ps_xb_w_bcEn,
    output astat, stky, illegal_op
  );

  modport slave (
    output instr_valid, instr,
    output alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av, mul_ps_mv, mul_ps_mn, shf_ps_sv, shf_ps_sz,
    input  instr_ready,
    input  ps_alu_en, ps_alu_log, ps_alu_sat, ps_alu_hc, ps_alu_sc,
    input  ps_mul_en, ps_mul_otreg, ps_mul_dtsts, ps_mul_cls, ps_mul_sc,
    input  ps_shf_en, ps_shf_cls,
    input  ps_xb_raddx, ps_xb_raddy, ps_xb_wadd, ps_xb_w_cuEn, ps_xb_w_bcEn,
    input  astat, stky, illegal_op
  );
endinterface

// File: rtl/ps_cu_dispatch_decode.sv
// Combinational decode of one compute instruction word into issue-stage
// control plus the writeback/hazard attributes the top needs.
module cu_instr_decode
  import cu_pkg::*;
(
  input  logic [31:0] instr,
  output issue_t      iss,
  output dec_t        dec
);
  logic [AW-1:0] rn, rx, ry;
  logic          unused_bits;

  assign rn = instr[RN_LSB +: AW];
  assign rx = instr[RX_LSB +: AW];
  assign ry = instr[RY_LSB +: AW];
  assign unused_bits = ^instr[7:0];

  always_comb begin
    iss = '0;
    dec = '0;
    case (cls_e'(instr[CLS_LSB +: 3]))
      CLS_ALU: begin
        iss.alu_en   = 1'b1;
        iss.alu_log  = instr[ALU_LOG];
        iss.alu_hc   = instr[ALU_HC_LSB +: 2];
        iss.alu_sc   = instr[ALU_SC_LSB +: 3];
        iss.alu_sat  = instr[ALU_SAT];
        iss.raddx    = rx;
        iss.raddy    = ry;
        dec.unit     = CU_ALU;
        dec.cu_en    = CU_ALU;
        dec.rn       = rn;
        dec.reads_rf = 1'b1;
      end
      CLS_MUL: begin
        iss.mul_en    = 1'b1;
        iss.mul_otreg = instr[MUL_OTREG];
        iss.mul_dtsts = instr[MUL_DT_LSB +: 4];
        iss.mul_cls   = instr[MUL_CLS_LSB +: 2];
        iss.mul_sc    = instr[MUL_SC_LSB +: 2];
        iss.raddx     = rx;
        iss.raddy     = ry;
        dec.unit      = CU_MUL;
        // results kept in MR never reach the register file
        dec.cu_en     = instr[MUL_OTREG] ? 3'b000 : CU_MUL;
        dec.rn        = rn;
        dec.reads_rf  = 1'b1;
      end
      CLS_SHF: begin
        iss.shf_en   = 1'b1;
        iss.shf_cls  = instr[SHF_CLS_LSB +: 2];
        iss.raddx    = rx;
        iss.raddy    = ry;
        dec.unit     = CU_SHF;
        dec.cu_en    = CU_SHF;
        dec.rn       = rn;
        dec.reads_rf = 1'b1;
      end
      CLS_BUSWR: begin
        dec.bc_en = 1'b1;
        dec.rn    = rn;
      end
      CLS_CLRF: dec.clr = 1'b1;
      CLS_NOP:  ;
      default:  dec.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/ps_cu_dispatch.sv
// Two-stage (ISSUE -> WRITEBACK) compute-unit dispatch with a one-bubble
// RAW stall and the astat/stky flag registers.
module ps_cu_dispatch
  import cu_pkg::*;
#(
  parameter int RF_DATASIZE   = 32,
  parameter int ADDRESS_WIDTH = 4,
  parameter int SIGNAL_WIDTH  = 3
) (
  input logic     clk,
  input logic     reset,
  ps_cu_if.master bus
);
  if (ADDRESS_WIDTH != AW || SIGNAL_WIDTH != 3 || RF_DATASIZE < 8) begin : g_bad_cfg
    $error("ps_cu_dispatch: unsupported parameter set");
  end

  issue_t        iss, iss_o;
  dec_t          dec;
  state_e        state, state_nx;
  logic          live, accept, hazard;
  logic [2:0]    wb_unit, wb_cu;
  logic          wb_bc;
  logic [AW-1:0] wb_rn;
  logic [7:0]    astat;
  logic [2:0]    stky;

  cu_instr_decode u_dec (.instr(bus.instr), .iss(iss), .dec(dec));

  // only a result headed for the RF through the crossbar can be read too early
  assign hazard = bus.instr_valid && dec.reads_rf && (wb_cu != 3'b000) &&
                  (iss.raddx == wb_rn || iss.raddy == wb_rn);
  assign bus.instr_ready = live && !(state == EXEC && hazard);
  assign accept = bus.instr_valid && bus.instr_ready;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, HOLD: state_nx = accept ? EXEC : IDLE;
      EXEC: begin
        if (accept)                           state_nx = EXEC;
        else if (bus.instr_valid && live)     state_nx = HOLD;
        else                                  state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // live holds instr_ready low until the first edge after reset releases
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live <= 1'b0; wb_unit <= '0; wb_cu <= '0; wb_bc <= 1'b0; wb_rn <= '0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        wb_unit <= dec.unit; wb_cu <= dec.cu_en; wb_bc <= dec.bc_en; wb_rn <= dec.rn;
      end else begin
        wb_unit <= '0; wb_cu <= '0; wb_bc <= 1'b0; wb_rn <= '0;
      end
    end
  end

  // a CLRFLAGS in issue is younger than the op in WB, so it wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      astat <= '0; stky <= '0;
    end else if (accept && dec.clr) begin
      astat <= '0; stky <= '0;
    end else begin
      if (wb_unit == CU_ALU) begin
        astat[AZ] <= bus.alu_ps_az; astat[AN] <= bus.alu_ps_an;
        astat[AC] <= bus.alu_ps_ac; astat[AV] <= bus.alu_ps_av;
        stky[STKY_AV] <= stky[STKY_AV] | bus.alu_ps_av;
      end
      if (wb_unit == CU_MUL) begin
        astat[MV] <= bus.mul_ps_mv; astat[MN] <= bus.mul_ps_mn;
        stky[STKY_MV] <= stky[STKY_MV] | bus.mul_ps_mv;
      end
      if (wb_unit == CU_SHF) begin
        astat[SV] <= bus.shf_ps_sv; astat[SZ] <= bus.shf_ps_sz;
        stky[STKY_SV] <= stky[STKY_SV] | bus.shf_ps_sv;
      end
    end
  end

  assign iss_o = accept ? iss : '0;

  assign bus.ps_alu_en    = iss_o.alu_en;
  assign bus.ps_alu_log   = iss_o.alu_log;
  assign bus.ps_alu_sat   = iss_o.alu_sat;
  assign bus.ps_alu_hc    = iss_o.alu_hc;
  assign bus.ps_alu_sc    = iss_o.alu_sc;
  assign bus.ps_mul_en    = iss_o.mul_en;
  assign bus.ps_mul_otreg = iss_o.mul_otreg;
  assign bus.ps_mul_dtsts = iss_o.mul_dtsts;
  assign bus.ps_mul_cls   = iss_o.mul_cls;
  assign bus.ps_mul_sc    = iss_o.mul_sc;
  assign bus.ps_shf_en    = iss_o.shf_en;
  assign bus.ps_shf_cls   = iss_o.shf_cls;
  assign bus.ps_xb_raddx  = iss_o.raddx;
  assign bus.ps_xb_raddy  = iss_o.raddy;
  assign bus.ps_xb_wadd   = wb_rn;
  assign bus.ps_xb_w_cuEn = wb_cu;
  assign bus.ps_xb_w_bcEn = wb_bc;
  assign bus.illegal_op   = accept && dec.illegal;
  assign bus.astat        = astat;
  assign bus.stky         = stky;
endmodule

// File: tb/tb_ps_cu_dispatch.sv
// Directed bench for ps_cu_dispatch: per-cycle reference model check plus
// hand-computed literal expectations for the key scenarios.
module tb_ps_cu_dispatch;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] flg = '0;
  int         checks = 0;
  int         failures = 0;

  ps_cu_if #(.ADDRESS_WIDTH(4), .SIGNAL_WIDTH(3)) bus ();

  ps_cu_dispatch #(.RF_DATASIZE(32), .ADDRESS_WIDTH(4), .SIGNAL_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic v, logic [31:0] ins, logic [7:0] f);
    bus.instr_valid = v;
    bus.instr       = ins;
    flg             = f;
    {bus.shf_ps_sz, bus.shf_ps_sv, bus.mul_ps_mn, bus.mul_ps_mv,
     bus.alu_ps_av, bus.alu_ps_ac, bus.alu_ps_an, bus.alu_ps_az} = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc(logic [2:0] c, int rn, int rx, int ry, logic [16:0] lo);
    return {c, 4'(rn), 4'(rx), 4'(ry), lo};
  endfunction

  // ---------------- reference model: one op in WB, flags as plain bytes ----------------
  logic       m_live = 0, m_wbv = 0, m_ot = 0, m_x = 0, m_xot = 0;
  logic [2:0] m_cls = 0, m_xc = 0;
  logic [3:0] m_rn = 0, m_xrn = 0;
  logic [7:0] m_astat = 0;
  logic [2:0] m_stky = 0;

  initial begin : model
    logic [2:0]  c, e_cu;
    logic [3:0]  rx, ry, rn, e_wadd;
    logic [31:0] ins;
    logic [28:0] e_iss;
    logic        unit, wb_wr, e_ready, x, e_bc, e_ill;
    forever begin
      @(negedge clk);
      ins = bus.instr;
      c = ins[31:29]; rn = ins[28:25]; rx = ins[24:21]; ry = ins[20:17];
      unit = (c == 3'd1 || c == 3'd2 || c == 3'd3);
      wb_wr = m_wbv && (m_cls == 3'd1 || m_cls == 3'd3 || (m_cls == 3'd2 && !m_ot));
      e_ready = m_live && !(bus.instr_valid && unit && wb_wr && (rx == m_rn || ry == m_rn));
      x = bus.instr_valid && e_ready;
      e_iss = {(x && c == 3'd1) ? {1'b1, ins[16], ins[10], ins[15:14], ins[13:11]} : 8'd0,
               (x && c == 3'd2) ? {1'b1, ins[16], ins[15:12], ins[11:10], ins[9:8]} : 10'd0,
               (x && c == 3'd3) ? {1'b1, ins[16:15]} : 3'd0,
               (x && unit) ? {rx, ry} : 8'd0};
      e_cu = 3'b000;
      if (m_wbv && m_cls == 3'd1) e_cu = 3'b001;
      if (m_wbv && m_cls == 3'd3) e_cu = 3'b010;
      if (m_wbv && m_cls == 3'd2 && !m_ot) e_cu = 3'b100;
      e_bc = m_wbv && m_cls == 3'd4;
      e_wadd = (m_wbv && m_cls >= 3'd1 && m_cls <= 3'd4) ? m_rn : 4'd0;
      e_ill = x && c >= 3'd6;
      if (reset) begin
        m_live = 0; m_wbv = 0; m_astat = 0; m_stky = 0;
        e_ready = 0; x = 0; e_iss = 0; e_cu = 0; e_bc = 0; e_wadd = 0; e_ill = 0;
      end
      chk("ready", bus.instr_ready, e_ready);
      chk("issue", {bus.ps_alu_en, bus.ps_alu_log, bus.ps_alu_sat, bus.ps_alu_hc, bus.ps_alu_sc,
                    bus.ps_mul_en, bus.ps_mul_otreg, bus.ps_mul_dtsts, bus.ps_mul_cls, bus.ps_mul_sc,
                    bus.ps_shf_en, bus.ps_shf_cls, bus.ps_xb_raddx, bus.ps_xb_raddy}, e_iss);
      chk("wb", {bus.ps_xb_w_cuEn, bus.ps_xb_w_bcEn, bus.ps_xb_wadd}, {e_cu, e_bc, e_wadd});
      chk("illegal", bus.illegal_op, e_ill);
      chk("astat", bus.astat, m_astat);
      chk("stky", bus.stky, m_stky);
      m_x = x; m_xc = c; m_xrn = rn; m_xot = ins[16];
      @(posedge clk);
      if (reset) begin
        m_live = 0; m_wbv = 0; m_astat = 0; m_stky = 0;
      end else begin
        if (m_wbv && m_cls == 3'd1) begin m_astat[3:0] = flg[3:0]; m_stky[0] |= flg[3]; end
        if (m_wbv && m_cls == 3'd2) begin m_astat[5:4] = flg[5:4]; m_stky[1] |= flg[4]; end
        if (m_wbv && m_cls == 3'd3) begin m_astat[7:6] = flg[7:6]; m_stky[2] |= flg[6]; end
        if (m_x && m_xc == 3'd5) begin m_astat = 0; m_stky = 0; end
        m_wbv = m_x; m_cls = m_xc; m_rn = m_xrn; m_ot = m_xot; m_live = 1;
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    drive(1'b0, 32'h0, 8'h00);
    #2;
    chk("rst_ready", bus.instr_ready, 0);
    chk("rst_astat", bus.astat, 0);
    chk("rst_cuen", bus.ps_xb_w_cuEn, 0);
    @(posedge clk); #1 reset = 1'b0;
    #1 chk("ready_before_edge", bus.instr_ready, 0);
    step();
    chk("ready_after_edge", bus.instr_ready, 1);

    // ALU R1 = R2 + R3, az raised in WB
    drive(1'b1, enc(3'd1, 1, 2, 3, 17'h0AC00), 8'h00);
    #1 chk("t1_alu_en", bus.ps_alu_en, 1);
    chk("t1_raddx", bus.ps_xb_raddx, 2);
    chk("t1_raddy", bus.ps_xb_raddy, 3);
    chk("t1_alu_sc", bus.ps_alu_sc, 5);
    step();
    drive(1'b0, 32'h0, 8'h01);
    #1 chk("t1_cuen", bus.ps_xb_w_cuEn, 3'b001);
    chk("t1_wadd", bus.ps_xb_wadd, 1);
    step();
    chk("t1_az", bus.astat[0], 1);

    // R4 = R1 + R1 then MUL R5 = R4 * R2: one bubble
    drive(1'b1, enc(3'd1, 4, 1, 1, 17'h0), 8'h00);
    #1 chk("t2_ready0", bus.instr_ready, 1);
    step();
    drive(1'b1, enc(3'd2, 5, 4, 2, 17'h09700), 8'h00);
    #1 chk("t2_stall", bus.instr_ready, 0);
    step();
    chk("t2_ready_hold", bus.instr_ready, 1);
    #1 chk("t2_mul_en", bus.ps_mul_en, 1);
    step();
    drive(1'b0, 32'h0, 8'h00);
    #1 chk("t2_cuen", bus.ps_xb_w_cuEn, 3'b100);
    chk("t2_wadd", bus.ps_xb_wadd, 5);
    step();

    // MUL otreg=1 with mv, then CLRFLAGS
    drive(1'b1, enc(3'd2, 6, 1, 2, 17'h19700), 8'h00);
    step();
    drive(1'b0, 32'h0, 8'h10);
    #1 chk("t3_cuen", bus.ps_xb_w_cuEn, 0);
    step();
    chk("t3_mv", bus.astat[4], 1);
    chk("t3_stky_mv", bus.stky[1], 1);
    drive(1'b1, enc(3'd5, 0, 0, 0, 17'h0), 8'h00);
    step();
    drive(1'b0, 32'h0, 8'h00);
    #1 chk("t3_clr_astat", bus.astat, 0);
    chk("t3_clr_stky", bus.stky, 0);
    step();

    // CLRFLAGS issued while an ALU with av sits in WB
    drive(1'b1, enc(3'd1, 8, 9, 10, 17'h0), 8'h00);
    step();
    drive(1'b1, enc(3'd5, 0, 0, 0, 17'h0), 8'h09);
    step();
    drive(1'b0, 32'h0, 8'h00);
    chk("t3b_astat", bus.astat, 0);
    chk("t3b_stky", bus.stky, 0);
    step();

    // BUSWR R7 then ALU reading R7 -- no stall
    drive(1'b1, enc(3'd4, 7, 0, 0, 17'h0), 8'h00);
    step();
    drive(1'b1, enc(3'd1, 8, 7, 7, 17'h0), 8'h00);
    #1 chk("t4_bcen", bus.ps_xb_w_bcEn, 1);
    chk("t4_wadd", bus.ps_xb_wadd, 7);
    chk("t4_cuen", bus.ps_xb_w_cuEn, 0);
    chk("t4_ready", bus.instr_ready, 1);
    step();

    // illegal class
    drive(1'b1, enc(3'd6, 1, 2, 3, 17'h1FFFF), 8'h00);
    #1 chk("t5_illegal", bus.illegal_op, 1);
    chk("t5_en", {bus.ps_alu_en, bus.ps_mul_en, bus.ps_shf_en}, 0);
    step();
    drive(1'b0, 32'h0, 8'h00);
    #1 chk("t5_nowrite", {bus.ps_xb_w_cuEn, bus.ps_xb_w_bcEn}, 0);
    chk("t5_pulse", bus.illegal_op, 0);
    step();

    // SHF sets sv sticky; independent ops back-to-back; Ry hazard on SHF result
    drive(1'b1, enc(3'd3, 2, 3, 4, 17'h10000), 8'h00);
    step();
    drive(1'b1, enc(3'd1, 5, 6, 7, 17'h0), 8'h40);
    #1 chk("t6_ready_b2b", bus.instr_ready, 1);
    step();
    chk("t6_stky_sv", bus.stky[2], 1);
    drive(1'b1, enc(3'd3, 9, 1, 1, 17'h08000), 8'h00);
    step();
    drive(1'b1, enc(3'd1, 1, 2, 9, 17'h0), 8'h00);
    #1 chk("t6_ry_stall", bus.instr_ready, 0);
    step();
    step();
    drive(1'b0, 32'h0, 8'h00);
    step();

    // reset during WB of an ALU op
    drive(1'b1, enc(3'd1, 3, 1, 2, 17'h0), 8'h00);
    step();
    drive(1'b0, 32'h0, 8'h00);
    #1 chk("t7_cuen_before", bus.ps_xb_w_cuEn, 3'b001);
    #1 reset = 1'b1;
    #1 chk("t7_cuen_reset", bus.ps_xb_w_cuEn, 0);
    chk("t7_ready_reset", bus.instr_ready, 0);
    @(posedge clk); #1 reset = 1'b0;
    step();
    chk("t7_ready_back", bus.instr_ready, 1);

    // mixed traffic on a small register set to provoke hazards
    for (int i = 0; i < 80; i++) begin
      drive($urandom_range(0, 3) != 0,
            {3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)), 17'($urandom)},
            8'($urandom));
      step();
    end
    drive(1'b0, 32'h0, 8'h00);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
